// File: rtl/alu16_pkg.sv
// Shared constants for the byte-serial 16-bit ALU.
// Op codes, controller states, flag bit positions and alu8 function codes.
package alu16_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SBC = 3'd2;
  localparam logic [2:0] OP_INC = 3'd3;
  localparam logic [2:0] OP_DEC = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam int F_S = 7;
  localparam int F_Z = 6;
  localparam int F_5 = 5;
  localparam int F_H = 4;
  localparam int F_3 = 3;
  localparam int F_V = 2;
  localparam int F_N = 1;
  localparam int F_C = 0;

  typedef enum logic [1:0] {
    FN_ADD,
    FN_SUB,
    FN_PASS
  } alu_fn_t;

endpackage

// File: rtl/alu16_alu8.sv
// 8-bit adder/subtractor shared by both byte phases.
// Subtract uses carry = not-borrow (a + ~b + cin).
module alu16_alu8
  import alu16_pkg::*;
(
  input  alu_fn_t    fn,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] res,
  output logic       cout,
  output logic       hc,
  output logic       v
);

  logic [7:0] bb;
  logic [8:0] sum;
  logic [4:0] nib;

  always_comb begin
    bb   = (fn == FN_SUB) ? ~b : b;
    sum  = {1'b0, a} + {1'b0, bb} + {8'd0, cin};
    nib  = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'd0, cin};
    res  = sum[7:0];
    cout = sum[8];
    hc   = nib[4];
    v    = (a[7] == bb[7]) && (sum[7] != a[7]);
    if (fn == FN_PASS) begin
      res  = a;
      cout = 1'b0;
      hc   = 1'b0;
      v    = 1'b0;
    end
  end

endmodule

// File: rtl/alu16_seq.sv
// Byte-serial 16-bit ADD/ADC/SBC over one shared 8-bit ALU, 3-cycle latency.
// Define ALU16_INC_DEC_EN to enable the INC16/DEC16 op codes.
module alu16_seq
  import alu16_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [7:0]  f_in,
  output logic        ready,
  output logic        done,
  output logic [15:0] out,
  output logic [7:0]  f
);

  state_t      state, nstate;
  logic [2:0]  op_q;
  logic [15:0] x_q, y_q;
  logic [7:0]  fq;
  logic [7:0]  lo_q;
  logic        lo_c;

  alu_fn_t     fn;
  logic [7:0]  a, b, res;
  logic        cin, cin0, zero_b;
  logic        cout, hc, v;
  logic        is_add, is_adc, is_sbc;
  logic        is_inc, is_dec;
  logic        accept, hi;
  logic [7:0]  fo;

  assign ready  = (state == IDLE) || (state == DONE);
  assign accept = start && ready;
  assign hi     = (state == HI);

  assign is_add = (op_q == OP_ADD);
  assign is_adc = (op_q == OP_ADC);
  assign is_sbc = (op_q == OP_SBC);
`ifdef ALU16_INC_DEC_EN
  assign is_inc = (op_q == OP_INC);
  assign is_dec = (op_q == OP_DEC);
`else
  assign is_inc = 1'b0;
  assign is_dec = 1'b0;
`endif

  always_comb begin
    fn     = FN_PASS;
    cin0   = 1'b0;
    zero_b = 1'b0;
    unique case (1'b1)
      is_add: fn = FN_ADD;
      is_adc: begin fn = FN_ADD; cin0 = fq[F_C]; end
      is_sbc: begin fn = FN_SUB; cin0 = ~fq[F_C]; end
      is_inc: begin fn = FN_ADD; cin0 = 1'b1; zero_b = 1'b1; end
      is_dec: begin fn = FN_SUB; zero_b = 1'b1; end
      default: fn = FN_PASS;
    endcase
    a   = hi ? x_q[15:8] : x_q[7:0];
    b   = zero_b ? 8'd0 : (hi ? y_q[15:8] : y_q[7:0]);
    cin = hi ? lo_c : cin0;
  end

  alu16_alu8 u_alu8 (
    .fn   (fn),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .res  (res),
    .cout (cout),
    .hc   (hc),
    .v    (v)
  );

  // Subtract reports borrow: invert the ALU's not-borrow carries
  always_comb begin
    fo = fq;
    unique case (1'b1)
      is_add: begin
        fo[F_H] = hc;
        fo[F_N] = 1'b0;
        fo[F_C] = cout;
      end
      is_adc: begin
        fo[F_S] = res[7];
        fo[F_Z] = ({res, lo_q} == 16'd0);
        fo[F_H] = hc;
        fo[F_V] = v;
        fo[F_N] = 1'b0;
        fo[F_C] = cout;
      end
      is_sbc: begin
        fo[F_S] = res[7];
        fo[F_Z] = ({res, lo_q} == 16'd0);
        fo[F_H] = ~hc;
        fo[F_V] = v;
        fo[F_N] = 1'b1;
        fo[F_C] = ~cout;
      end
      default: fo = fq;
    endcase
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = LO;
      LO:      nstate = HI;
      HI:      nstate = DONE;
      DONE:    nstate = start ? LO : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      op_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      fq    <= '0;
      lo_q  <= '0;
      lo_c  <= 1'b0;
      out   <= '0;
      f     <= '0;
      done  <= 1'b0;
    end else begin
      state <= nstate;
      done  <= (state == DONE);
      if (accept) begin
        op_q <= op;
        x_q  <= x;
        y_q  <= y;
        fq   <= f_in;
      end
      if (state == LO) begin
        lo_q <= res;
        lo_c <= cout;
      end
      if (hi) begin
        out <= {res, lo_q};
        f   <= fo;
      end
    end
  end

endmodule

// File: doc/alu16_seq.md
ALU16_SEQ -- requirements
Module: alu16_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request pulse, sampled when ready=1.
REQ-004 SHALL have port op, input, 3, operation: 0 ADD16, 1 ADC16, 2 SBC16, 3 INC16, 4 DEC16.
REQ-005 SHALL have port x, input, 16, first operand (HL side).
REQ-006 SHALL have port y, input, 16, second operand (rr side).
REQ-007 SHALL have port f_in, input, 8, flags at request (S7 Z6 H4 V2 N1 C0).
REQ-008 SHALL have port ready, output, 1, request can be accepted this cycle.
REQ-009 SHALL have port done, output, 1, one-cycle pulse, result valid.
REQ-010 SHALL have port out, output, 16, result, held until next accepted start.
REQ-011 SHALL have port f, output, 8, result flags, held with out.

Function
REQ-012 SHALL contain states IDLE, LO, HI, DONE; ready=1 only in IDLE and DONE.
REQ-013 start with ready=1 SHALL capture op, x, y, f_in and go to LO; start with ready=0 SHALL be ignored, not queued.
REQ-014 LO SHALL compute low byte through the shared 8-bit ALU and register low result and low carry/borrow; next state HI.
REQ-015 HI SHALL compute high byte through the same ALU, carry/borrow-in = low carry/borrow-out; next state DONE.
REQ-016 DONE SHALL assert done=1 for exactly one cycle; next state IDLE, or LO if start accepted in DONE (back-to-back, no bubble).
REQ-017 Latency SHALL be 3 cycles: start accepted at edge N, done=1 after edge N+3.
REQ-018 ADD16: out = x+y mod 2^16; H = carry from bit 11; C = carry from bit 15; N=0; S, Z, V, bits 5, 3 = f_in.
REQ-019 ADC16: out = x+y+f_in.C; S = out[15]; Z = (out==0, all 16 bits); H = carry bit 11; V = signed 16-bit overflow; N=0; C = carry bit 15.
REQ-020 SBC16: out = x-y-f_in.C; S, Z as ADC16; H = borrow from bit 12; V = signed overflow; N=1; C = borrow from bit 16 (C=1 means borrow).
REQ-021 The controller SHALL normalise the ALU subtract carry polarity so REQ-020 holds regardless of the 8-bit ALU's carry convention.
REQ-022 Bits 5 and 3 of f SHALL equal f_in bits 5 and 3 for every op.
REQ-023 Undefined op codes SHALL complete with normal latency, out = x, f = f_in.

Reset
REQ-024 reset_n=0 SHALL immediately force state IDLE, ready=1, done=0, out=16'h0000, f=8'h00.
REQ-025 Reset in LO/HI/DONE SHALL abort the operation with no done pulse; first start after release behaves as from IDLE.

Configuration
REQ-026 With ALU16_INC_DEC_EN defined, INC16 SHALL give out=x+1 and DEC16 out=x-1 (mod 2^16), f=f_in, same 3-cycle latency via the shared ALU.
REQ-027 Without ALU16_INC_DEC_EN, op 3 and 4 SHALL be undefined per REQ-023.

Structure
REQ-028 Package alu16_pkg SHALL hold op code constants, state enum, flag bit index constants, 8-bit ALU function codes.
REQ-029 SHALL instantiate exactly one alu8 sub-module, multiplexed between low and high byte phases.

Verification
REQ-030 ADD16 x=16'h0FFF y=16'h0001 f_in=8'hC4 -> done at N+3, out=16'h1000, f: H=1, C=0, N=0, S=1, Z=1, V=1 preserved.
REQ-031 ADC16 x=16'h7FFF y=16'h0000 f_in.C=1 -> out=16'h8000, S=1, Z=0, V=1, H=1, C=0, N=0.
REQ-032 SBC16 x=16'h0000 y=16'h0001 f_in.C=0 -> out=16'hFFFF, S=1, Z=0, H=1, V=0, N=1, C=1.
REQ-033 SBC16 x=16'h1234 y=16'h1233 f_in.C=1 -> out=16'h0000, Z=1, C=0, N=1; back-to-back start in DONE accepted, second done exactly 3 cycles later.
REQ-034 start during LO ignored; reset_n=0 during HI -> no done, out=0, f=0, ready=1 immediately.
REQ-035 With ALU16_INC_DEC_EN: DEC16 x=16'h0000 f_in=8'h55 -> out=16'hFFFF, f=8'h55; without macro same stimulus -> out=16'h0000, f=8'h55.
